// File: rtl/bist_pkg.sv
// bist_pkg: shared definitions for the March C- BIST controller.
// Holds the FSM state encoding, the element index constants M0..M5,
// the per-element direction/op-count/background table and the background patterns.
package bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_TAIL = 2'd2,
        ST_DONE = 2'd3
    } bistState_e;

    localparam logic [2:0] M0 = 3'd0;
    localparam logic [2:0] M1 = 3'd1;
    localparam logic [2:0] M2 = 3'd2;
    localparam logic [2:0] M3 = 3'd3;
    localparam logic [2:0] M4 = 3'd4;
    localparam logic [2:0] M5 = 3'd5;

    // Background patterns. Users slice the low DATA_SIZE bits, so any word
    // width up to BG_MAX_WIDTH gets an all-0 / all-1 pattern of its own width.
    localparam int BG_MAX_WIDTH = 64;
    localparam logic [BG_MAX_WIDTH-1:0] BG0 = '0;
    localparam logic [BG_MAX_WIDTH-1:0] BG1 = '1;

    // One March element:
    //   down      : address order is N-1..0 instead of 0..N-1
    //   twoOp     : element is (read, write) per address instead of a single op
    //   firstRead : first (or only) op is a read
    //   readBg    : background expected by the read (0 = BG0, 1 = BG1)
    //   writeBg   : background written by the write
    typedef struct packed {
        logic down;
        logic twoOp;
        logic firstRead;
        logic readBg;
        logic writeBg;
    } elemCfg_t;

    // March C-: up(w0); up(r0,w1); up(r1,w0); down(r0,w1); down(r1,w0); up(r0)
    function automatic elemCfg_t getElemCfg(input logic [2:0] elem);
        elemCfg_t cfg;
        cfg = '0;
        case (elem)
            M0: cfg = '{down: 1'b0, twoOp: 1'b0, firstRead: 1'b0, readBg: 1'b0, writeBg: 1'b0};
            M1: cfg = '{down: 1'b0, twoOp: 1'b1, firstRead: 1'b1, readBg: 1'b0, writeBg: 1'b1};
            M2: cfg = '{down: 1'b0, twoOp: 1'b1, firstRead: 1'b1, readBg: 1'b1, writeBg: 1'b0};
            M3: cfg = '{down: 1'b1, twoOp: 1'b1, firstRead: 1'b1, readBg: 1'b0, writeBg: 1'b1};
            M4: cfg = '{down: 1'b1, twoOp: 1'b1, firstRead: 1'b1, readBg: 1'b1, writeBg: 1'b0};
            M5: cfg = '{down: 1'b0, twoOp: 1'b0, firstRead: 1'b1, readBg: 1'b0, writeBg: 1'b0};
            default: cfg = '0;
        endcase
        return cfg;
    endfunction

endpackage

// File: rtl/bist_addr_gen.sv
// bist_addr_gen: loadable up/down address counter for the March sequencer.
// load_i reloads to 0 or N-1 (loadHigh_i); step_i moves one address in the
// direction given by down_i; term_o flags the last address of that direction.
module bist_addr_gen #(
    parameter int ADR_SIZE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic                loadHigh_i,
    input  logic                step_i,
    input  logic                down_i,
    output logic [ADR_SIZE-1:0] addr_o,
    output logic                term_o
);

    localparam logic [ADR_SIZE-1:0] ADDR_MAX = '1;
    localparam logic [ADR_SIZE-1:0] ADDR_ONE = {{(ADR_SIZE-1){1'b0}}, 1'b1};

    logic [ADR_SIZE-1:0] addr_q;
    logic [ADR_SIZE-1:0] addr_d;

    // Reload has priority over stepping so an element change never leaks a wrap.
    always_comb begin
        addr_d = addr_q;
        if (load_i) begin
            addr_d = loadHigh_i ? ADDR_MAX : '0;
        end else if (step_i) begin
            addr_d = down_i ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
        end
    end

    // Address register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;
    assign term_o = down_i ? (addr_q == '0) : (addr_q == ADDR_MAX);

endmodule

// File: rtl/bist_march_ctrl.sv
// bist_march_ctrl: March C- BIST sequencer for a 2**ADR_SIZE x DATA_SIZE RAM.
// Issues one registered RAM op per cycle, compares each read one cycle later
// and keeps a sticky status flag. Optional first-fail capture is enabled by
// defining BIST_FAIL_LOG_EN (adds fail_addr / fail_elem outputs).
module bist_march_ctrl
    import bist_pkg::*;
#(
    parameter int ADR_SIZE  = 4,
    parameter int DATA_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 mem_re,
    output logic                 mem_we,
    output logic [ADR_SIZE-1:0]  mem_addr,
    output logic [DATA_SIZE-1:0] mem_wdata,
    input  logic [DATA_SIZE-1:0] mem_rdata,
    output logic                 status,
    output logic                 done
`ifdef BIST_FAIL_LOG_EN
    ,
    output logic [ADR_SIZE-1:0]  fail_addr,
    output logic [2:0]           fail_elem
`endif
);

    localparam logic [DATA_SIZE-1:0] BG_ZERO = BG0[DATA_SIZE-1:0];
    localparam logic [DATA_SIZE-1:0] BG_ONE  = BG1[DATA_SIZE-1:0];

    bistState_e state_q, state_d;
    logic [2:0]           elem_q, elem_d;
    logic                 phase_q, phase_d;
    logic                 seqDone_q, seqDone_d;
    logic                 memRe_q, memRe_d;
    logic                 memWe_q, memWe_d;
    logic [ADR_SIZE-1:0]  memAddr_q, memAddr_d;
    logic [DATA_SIZE-1:0] memWdata_q, memWdata_d;
    logic                 opBg_q, opBg_d;
    logic                 cmpValid_q;
    logic                 cmpBg_q;
    logic                 status_q, status_d;

    elemCfg_t             cfgCur;
    logic                 nextDown;
    logic                 opIsRead;
    logic                 issue;
    logic                 startAccept;
    logic                 mismatch;
    logic                 agLoad, agLoadHigh, agStep, agTerm;
    logic [ADR_SIZE-1:0]  agAddr;

    assign cfgCur      = getElemCfg(elem_q);
    assign nextDown    = getElemCfg(elem_q + 3'd1).down;
    assign opIsRead    = cfgCur.twoOp ? ~phase_q : cfgCur.firstRead;
    assign issue       = (state_q == ST_RUN) && !seqDone_q;
    assign startAccept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign mismatch    = cmpValid_q && (mem_rdata != (cmpBg_q ? BG_ONE : BG_ZERO));

    bist_addr_gen #(
        .ADR_SIZE (ADR_SIZE)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst),
        .load_i     (agLoad),
        .loadHigh_i (agLoadHigh),
        .step_i     (agStep),
        .down_i     (cfgCur.down),
        .addr_o     (agAddr),
        .term_o     (agTerm)
    );

    // Next-state logic: FSM, element/phase sequencing and the registered RAM op.
    always_comb begin
        state_d    = state_q;
        elem_d     = elem_q;
        phase_d    = phase_q;
        seqDone_d  = seqDone_q;
        memRe_d    = 1'b0;
        memWe_d    = 1'b0;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        opBg_d     = opBg_q;
        status_d   = status_q | mismatch;
        agLoad     = 1'b0;
        agLoadHigh = 1'b0;
        agStep     = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    elem_d    = M0;
                    phase_d   = 1'b0;
                    seqDone_d = 1'b0;
                    status_d  = 1'b0;
                    agLoad    = 1'b1;
                end
            end
            ST_RUN: begin
                if (seqDone_q) begin
                    state_d = ST_TAIL;
                end else begin
                    memRe_d   = opIsRead;
                    memWe_d   = ~opIsRead;
                    memAddr_d = agAddr;
                    opBg_d    = cfgCur.readBg;
                    if (!opIsRead) begin
                        memWdata_d = cfgCur.writeBg ? BG_ONE : BG_ZERO;
                    end
                    if (cfgCur.twoOp && !phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (agTerm) begin
                            if (elem_q == M5) begin
                                seqDone_d = 1'b1;
                            end else begin
                                elem_d     = elem_q + 3'd1;
                                agLoad     = 1'b1;
                                agLoadHigh = nextDown;
                            end
                        end else begin
                            agStep = 1'b1;
                        end
                    end
                end
            end
            ST_TAIL: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, RAM-port and read-compare pipeline registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            elem_q     <= M0;
            phase_q    <= 1'b0;
            seqDone_q  <= 1'b0;
            memRe_q    <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            opBg_q     <= 1'b0;
            cmpValid_q <= 1'b0;
            cmpBg_q    <= 1'b0;
            status_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            elem_q     <= elem_d;
            phase_q    <= phase_d;
            seqDone_q  <= seqDone_d;
            memRe_q    <= memRe_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            opBg_q     <= opBg_d;
            cmpValid_q <= memRe_q;
            cmpBg_q    <= opBg_q;
            status_q   <= status_d;
        end
    end

`ifdef BIST_FAIL_LOG_EN
    logic [2:0]          opElem_q, cmpElem_q, failElem_q;
    logic [ADR_SIZE-1:0] cmpAddr_q, failAddr_q;

    // Carry element/address alongside each read and latch the first miscompare only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opElem_q   <= M0;
            cmpElem_q  <= M0;
            cmpAddr_q  <= '0;
            failElem_q <= M0;
            failAddr_q <= '0;
        end else begin
            if (issue) begin
                opElem_q <= elem_q;
            end
            cmpElem_q <= opElem_q;
            cmpAddr_q <= memAddr_q;
            if (startAccept) begin
                failElem_q <= M0;
                failAddr_q <= '0;
            end else if (mismatch && !status_q) begin
                failElem_q <= cmpElem_q;
                failAddr_q <= cmpAddr_q;
            end
        end
    end

    assign fail_addr = failAddr_q;
    assign fail_elem = failElem_q;
`else
    logic unusedSeq;
    assign unusedSeq = issue ^ startAccept;
`endif

    assign mem_re    = memRe_q;
    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
    assign status    = status_q;
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_bist_march_ctrl.sv
// tb_bist_march_ctrl: self-checking bench for bist_march_ctrl with a
// behavioural 1-cycle-latency RAM, stuck-at and forced-read fault injection.
// Build with BIST_FAIL_LOG_EN defined to also check the first-fail log.
module tb_bist_march_ctrl;

    localparam int ADR_SIZE  = 4;
    localparam int DATA_SIZE = 8;
    localparam int N         = 16;
    localparam int DONE_EDGE = 10 * N + 2;
    localparam int STUCK_ADR = 5;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic                 mem_re;
    logic                 mem_we;
    logic [ADR_SIZE-1:0]  mem_addr;
    logic [DATA_SIZE-1:0] mem_wdata;
    logic [DATA_SIZE-1:0] mem_rdata;
    logic                 status;
    logic                 done;
`ifdef BIST_FAIL_LOG_EN
    logic [ADR_SIZE-1:0]  fail_addr;
    logic [2:0]           fail_elem;
`endif

    logic [DATA_SIZE-1:0] ram [N];
    logic [DATA_SIZE-1:0] ramQ;
    logic                 stuckEn;
    logic                 forceFf;

    int nCompared;
    int nMismatched;

    typedef struct {
        logic                 isWrite;
        logic [ADR_SIZE-1:0]  addr;
        logic [DATA_SIZE-1:0] data;
    } expOp_t;

    expOp_t expQ[$];

    bist_march_ctrl #(
        .ADR_SIZE  (ADR_SIZE),
        .DATA_SIZE (DATA_SIZE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .status    (status),
`ifdef BIST_FAIL_LOG_EN
        .done      (done),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem)
`else
        .done      (done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: synchronous write, registered read, optional stuck-at-1 on bit 0.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) ramQ <= ram[mem_addr] | (((stuckEn == 1'b1) && (mem_addr == ADR_SIZE'(STUCK_ADR))) ? 8'h01 : 8'h00);
    end

    assign mem_rdata = forceFf ? 8'hFF : ramQ;

    task automatic pushOp(input logic isWrite, input int addr, input logic [DATA_SIZE-1:0] data);
        expOp_t op;
        op.isWrite = isWrite;
        op.addr    = ADR_SIZE'(addr);
        op.data    = data;
        expQ.push_back(op);
    endtask

    // Reference March C- op stream written straight from the algorithm.
    task automatic buildExpected();
        expQ.delete();
        for (int a = 0; a < N; a++) pushOp(1'b1, a, 8'h00);
        for (int a = 0; a < N; a++) begin pushOp(1'b0, a, 8'h00); pushOp(1'b1, a, 8'hFF); end
        for (int a = 0; a < N; a++) begin pushOp(1'b0, a, 8'hFF); pushOp(1'b1, a, 8'h00); end
        for (int a = N - 1; a >= 0; a--) begin pushOp(1'b0, a, 8'h00); pushOp(1'b1, a, 8'hFF); end
        for (int a = N - 1; a >= 0; a--) begin pushOp(1'b0, a, 8'hFF); pushOp(1'b1, a, 8'h00); end
        for (int a = 0; a < N; a++) pushOp(1'b0, a, 8'h00);
    endtask

    // Runs one full March from a start pulse and checks ops, timing, status and log.
    task automatic runMarch(input string tag, input int repulseAt, input int forceAt,
                            input logic expStatus, input int expStatusEdge,
                            input logic [ADR_SIZE-1:0] expFailAddr, input logic [2:0] expFailElem);
        int     doneEdge;
        int     statusEdge;
        int     nReads;
        int     nWrites;
        expOp_t want;
        doneEdge   = -1;
        statusEdge = -1;
        nReads     = 0;
        nWrites    = 0;
        buildExpected();
        $display("[TB] %s: expect status=%0b at edge %0d, first fail addr %0d elem %0d",
                 tag, expStatus, expStatusEdge, expFailAddr, expFailElem);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nCompared++;
        if ({status, done, mem_re, mem_we} !== 4'b0000) begin
            nMismatched++;
            $display("[TB] FAIL %s start_edge: got status/done/re/we=%b want 0000", tag, {status, done, mem_re, mem_we});
        end
        for (int i = 1; i <= 400 && doneEdge < 0; i++) begin
            @(negedge clk);
            start = (i == repulseAt) ? 1'b1 : 1'b0;
            if (i == forceAt) forceFf = 1'b1;
            if (i == forceAt + 2) forceFf = 1'b0;
            if (mem_re === 1'b1 || mem_we === 1'b1) begin
                nCompared++;
                if (mem_re === 1'b1 && mem_we === 1'b1) begin
                    nMismatched++;
                    $display("[TB] FAIL %s re_we_overlap at edge %0d: got re=1 we=1 want exclusive", tag, i);
                end
                if (mem_we === 1'b1) nWrites++;
                else nReads++;
                nCompared++;
                if (expQ.size() == 0) begin
                    nMismatched++;
                    $display("[TB] FAIL %s extra_op at edge %0d: got we=%b addr=%0d want no op", tag, i, mem_we, mem_addr);
                end else begin
                    want = expQ.pop_front();
                    if ({mem_we, mem_addr} !== {want.isWrite, want.addr}) begin
                        nMismatched++;
                        $display("[TB] FAIL %s op_seq at edge %0d: got we=%b addr=%0d want we=%b addr=%0d",
                                 tag, i, mem_we, mem_addr, want.isWrite, want.addr);
                    end else if (want.isWrite && (mem_wdata !== want.data)) begin
                        nMismatched++;
                        $display("[TB] FAIL %s wdata at edge %0d: got %h want %h", tag, i, mem_wdata, want.data);
                    end
                end
            end
            if (status === 1'b1 && statusEdge < 0) statusEdge = i;
            if (done === 1'b1) doneEdge = i;
        end
        start   = 1'b0;
        forceFf = 1'b0;
        nCompared++;
        if (doneEdge != DONE_EDGE) begin
            nMismatched++;
            $display("[TB] FAIL %s done_edge: got %0d want %0d", tag, doneEdge, DONE_EDGE);
        end
        nCompared++;
        if (nReads != 5 * N || nWrites != 5 * N || expQ.size() != 0) begin
            nMismatched++;
            $display("[TB] FAIL %s op_count: got reads=%0d writes=%0d left=%0d want %0d/%0d/0",
                     tag, nReads, nWrites, expQ.size(), 5 * N, 5 * N);
        end
        nCompared++;
        if (status !== expStatus || statusEdge != expStatusEdge) begin
            nMismatched++;
            $display("[TB] FAIL %s status: got %b first at edge %0d want %b at edge %0d",
                     tag, status, statusEdge, expStatus, expStatusEdge);
        end
`ifdef BIST_FAIL_LOG_EN
        nCompared++;
        if (fail_addr !== expFailAddr || fail_elem !== expFailElem) begin
            nMismatched++;
            $display("[TB] FAIL %s fail_log: got addr=%0d elem=%0d want addr=%0d elem=%0d",
                     tag, fail_addr, fail_elem, expFailAddr, expFailElem);
        end
`endif
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        start   = 1'b0;
        stuckEn = 1'b0;
        forceFf = 1'b0;
        #2 rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            nCompared++;
            if ({mem_re, mem_we, mem_addr, mem_wdata, status, done} !== '0) begin
                nMismatched++;
                $display("[TB] FAIL reset_hold cycle %0d: got re=%b we=%b addr=%0d wdata=%h status=%b done=%b want all 0",
                         c, mem_re, mem_we, mem_addr, mem_wdata, status, done);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        nCompared++;
        if ({mem_re, mem_we, status, done} !== 4'b0000) begin
            nMismatched++;
            $display("[TB] FAIL reset_release: got re/we/status/done=%b want 0000", {mem_re, mem_we, status, done});
        end
    endtask

    task automatic test_fault_free();
        runMarch("fault_free", -1, -1, 1'b0, -1, '0, 3'd0);
    endtask

    // M1 reads addr 5 as op 16 + 2*5 + 1; status rises two edges after it is issued.
    task automatic test_stuck_at();
        stuckEn = 1'b1;
        runMarch("stuck_at", -1, -1, 1'b1, N + 2 * STUCK_ADR + 1 + 2, ADR_SIZE'(STUCK_ADR), 3'd1);
        stuckEn = 1'b0;
    endtask

    // Starts from DONE with status set: restart must clear it; mid-run start is ignored.
    task automatic test_back_to_back();
        nCompared++;
        if ({done, status} !== 2'b11) begin
            nMismatched++;
            $display("[TB] FAIL b2b_pre: got done/status=%b want 11", {done, status});
        end
        runMarch("restart_repulse", 50, -1, 1'b0, -1, '0, 3'd0);
    endtask

    // Forcing FF around the M1 read of addr 1 (issued at edge 19) hits its compare edge 21.
    task automatic test_force_ff();
        runMarch("force_ff", -1, 20, 1'b1, N + 2 * 1 + 1 + 2, ADR_SIZE'(1), 3'd1);
    endtask

    task automatic test_reset_mid_run();
        stuckEn = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (85) @(negedge clk);
        nCompared++;
        if ({status, mem_re | mem_we} !== 2'b11) begin
            nMismatched++;
            $display("[TB] FAIL mid_run_pre: got status/active=%b want 11", {status, mem_re | mem_we});
        end
        #1 rst = 1'b0;
        #1;
        nCompared++;
        if ({mem_re, mem_we, mem_addr, mem_wdata, status, done} !== '0) begin
            nMismatched++;
            $display("[TB] FAIL mid_run_reset: got re=%b we=%b addr=%0d wdata=%h status=%b done=%b want all 0",
                     mem_re, mem_we, mem_addr, mem_wdata, status, done);
        end
`ifdef BIST_FAIL_LOG_EN
        nCompared++;
        if ({fail_addr, fail_elem} !== '0) begin
            nMismatched++;
            $display("[TB] FAIL mid_run_log_clear: got addr=%0d elem=%0d want 0/0", fail_addr, fail_elem);
        end
`endif
        repeat (3) begin
            @(negedge clk);
            nCompared++;
            if ({mem_re, mem_we, done} !== 3'b000) begin
                nMismatched++;
                $display("[TB] FAIL mid_run_idle: got re/we/done=%b want 000", {mem_re, mem_we, done});
            end
        end
        rst     = 1'b1;
        stuckEn = 1'b0;
        runMarch("after_reset", -1, -1, 1'b0, -1, '0, 3'd0);
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        ramQ        = '0;
        for (int a = 0; a < N; a++) ram[a] = 8'hA5;
        test_reset();
        test_fault_free();
        test_stuck_at();
        test_back_to_back();
        test_force_ff();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
